bus_arbiter_4req: RTL
=====================

// Module: bus_arbiter_4req
// PURPOSE
//  Round-robin arbiter sharing one N-bit datapath (e.g. a 64-bit regfile/memory
//  write bus) among 4 requesters. Registers a one-hot grant and a 2-bit mux select.
//  Steers the selected requester's data onto the bus through a 4:1 N-bit mux
//  (I0..I3 = data0..data3). Enforces a per-grant hold limit so no requester starves others.
// PARAMETERS
//  N         64  datapath width
//  MAX_HOLD  8   max consecutive grant cycles while others wait; 0 = unlimited
//  CNT_W     4   width of hold counter; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//  clk       in   1    clock; all state updates on rising edge
//  reset     in   1    synchronous, active-high reset
//  req       in   4    request per requester; held high while it needs the bus
//  data0..3  in   N    requester data, one port per requester
//  gnt       out  4    one-hot grant (registered); 0 when idle
//  sel       out  2    index of granted requester (registered), drives mux S
//  bus_valid out  1    1 while in GRANT state (registered)
//  bus_data  out  N    data of sel when bus_valid, else 0 (combinational from sel)
// BEHAVIOUR
//  Reset (clk edge with reset=1): state=IDLE, gnt=0, sel=0, bus_valid=0,
//   hold_cnt=0, rr pointer ptr=0 (requester 0 highest priority). Reset wins over all.
//  RR pick: first asserted req scanning ptr, ptr+1, .. mod 4. After granting idx,
//   ptr <= idx+1 mod 4.
//  IDLE: if req!=0, pick, then GRANT with gnt=onehot(idx), sel=idx, hold_cnt=0.
//   Else stay. Latency: req high at edge t -> gnt visible after edge t+1.
//  GRANT, req[sel]=0 (release): pick among remaining reqs and switch directly
//   (no idle bubble). If none remain, go IDLE, gnt=0, bus_valid=0.
//  GRANT, req[sel]=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, other req pending:
//   forced rotate. Pick from sel+1 scanning, excluding sel, and set hold_cnt=0.
//  GRANT, req[sel]=1 otherwise: keep grant; hold_cnt saturating increment.
//   A lone requester holds indefinitely.
//  Simultaneous new reqs with release/rotate: resolved by the same RR pick that cycle.
//  gnt always one-hot or zero; sel stable while granted; sel holds last value in IDLE.
//  bus_data = bus_valid ? mux(sel) : 0, zero-latency from registered sel.
//  Requester dropping req while not granted: simply not considered; no memory of it.
// TESTING
//  1 reset, then req=0001 -> after 1 edge gnt=0001, sel=0, bus_valid=1,
//    bus_data=data0 (e.g. 64'hA5A5). req=0 -> next edge gnt=0, bus_data=0.
//  2 after reset, req=1111, each drops req 1 cycle after its grant -> grant order
//    0,1,2,3 with no idle cycles between grants.
//  3 MAX_HOLD=8, req0 and req2 held high -> gnt=0001 for 8 cycles, then 0100 for
//    8 cycles, repeating. req1/req3 never granted.
//  4 req=0010 held 20 cycles, no others -> gnt=0010 all 20 cycles, no rotation.
//  5 gnt=0100 (ptr=3), then req=1011 on release -> next grant is requester 3, then 0, then 1.
//  6 reset asserted mid-grant -> next edge gnt=0, bus_valid=0. With req=1111 then
//    granted to requester 0 (ptr reset).

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Bundle of request, data and granted-bus signals shared by the 4-way arbiter and its requesters.
// bus_valid qualifies bus_data/sel/gnt for the whole cycle; there is no ready -- a requester owns the bus while gnt is set.
interface bus_arbiter_if #(
  parameter int N = 64
);
  logic [3:0]   req;
  logic [N-1:0] data0;
  logic [N-1:0] data1;
  logic [N-1:0] data2;
  logic [N-1:0] data3;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic         bus_valid;
  logic [N-1:0] bus_data;

  modport master (
    output req, data0, data1, data2, data3,
    input  gnt, sel, bus_valid, bus_data
  );

  modport slave (
    input  req, data0, data1, data2, data3,
    output gnt, sel, bus_valid, bus_data
  );
endinterface

// File: rtl/bus_arbiter_4req.sv
// Round-robin arbiter for 4 requesters with a per-grant hold limit, steering the
// granted requester's data onto a shared N-bit bus.
module bus_arbiter_4req #(
  parameter int N        = 64,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic           clk,
  input  logic           reset,
  bus_arbiter_if.slave   bus,
  output logic           state_dbg
);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_n;
  logic [3:0]       gnt_n;
  logic [1:0]       sel_n;
  logic             valid_n;
  logic [CNT_W-1:0] hold_cnt, cnt_n;
  logic [1:0]       ptr, ptr_n;
  logic [2:0]       pick_all, pick_oth;
  logic [3:0]       others;

  // Returns {found, idx}: first set bit of r scanning p, p+1, .. mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_n  = state;
    gnt_n    = bus.gnt;
    sel_n    = bus.sel;
    valid_n  = bus.bus_valid;
    cnt_n    = hold_cnt;
    ptr_n    = ptr;
    others   = bus.req & ~(4'b0001 << bus.sel);
    pick_all = rr_pick(bus.req, ptr);
    pick_oth = rr_pick(others, ptr);
    case (state)
      S_IDLE: begin
        if (pick_all[2]) begin
          state_n = S_GRANT;
          gnt_n   = 4'b0001 << pick_all[1:0];
          sel_n   = pick_all[1:0];
          valid_n = 1'b1;
          cnt_n   = '0;
          ptr_n   = pick_all[1:0] + 2'd1;
        end
      end
      S_GRANT: begin
        if (!bus.req[bus.sel] ||
            (MAX_HOLD != 0 && hold_cnt >= HOLD_LAST && others != 4'b0000)) begin
          // Release or forced rotation both hand over straight to the next in line.
          if (pick_oth[2]) begin
            gnt_n   = 4'b0001 << pick_oth[1:0];
            sel_n   = pick_oth[1:0];
            cnt_n   = '0;
            ptr_n   = pick_oth[1:0] + 2'd1;
          end else begin
            state_n = S_IDLE;
            gnt_n   = 4'b0000;
            valid_n = 1'b0;
          end
        end else if (hold_cnt != {CNT_W{1'b1}}) begin
          cnt_n = hold_cnt + CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      bus.gnt       <= 4'b0000;
      bus.sel       <= 2'd0;
      bus.bus_valid <= 1'b0;
      hold_cnt      <= '0;
      ptr           <= 2'd0;
    end else begin
      state         <= state_n;
      bus.gnt       <= gnt_n;
      bus.sel       <= sel_n;
      bus.bus_valid <= valid_n;
      hold_cnt      <= cnt_n;
      ptr           <= ptr_n;
    end
  end

  always_comb begin
    bus.bus_data = '0;
    if (bus.bus_valid) begin
      case (bus.sel)
        2'd0:    bus.bus_data = bus.data0;
        2'd1:    bus.bus_data = bus.data1;
        2'd2:    bus.bus_data = bus.data2;
        default: bus.bus_data = bus.data3;
      endcase
    end
  end

  assign state_dbg = state;

endmodule
